clock_controller: RTL and testbench

- Sequences the CPU slow clock.
- Auto mode: free-runs at fastClk/(2*(DIV_MAX+1)).
- Manual mode: a debounced pushbutton produces exactly one clock period per press.
- A HLT request from the control logic stops the clock glitch-free until reset.
- Sits between the 12 MHz board clock and every slowClk consumer. Also emits a single-fastClk-cycle rising-edge strobe for logic kept in the fastClk domain.

---
 rtl/clock_pkg.sv | 6 +
 rtl/button_debounce.sv | 40 ++++
 rtl/clock_controller.sv | 78 +++++++
 tb/tb_clock_controller.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared state encoding and default timing constants for the CPU clock controller
package clock_pkg;
    typedef enum logic [1:0] {LOW, HIGH, HALTED} clkState_t;
    localparam int DIV_MAX_DEF = 1000;
    localparam int DEBOUNCE_DEF = 120000;
endpackage

// File: rtl/button_debounce.sv
// button_debounce: synchronises and debounces a raw pushbutton, emitting a pulse on each debounced press
// fastClk in: clock; reset in: async active-high; rawBtn in: async button level
// debounced out: filtered level; risePulse out: one-cycle strobe, high in the cycle debounced first reads 1
module button_debounce
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int CNT_W = 32
) (
    input  logic fastClk,
    input  logic reset,
    input  logic rawBtn,
    output logic debounced,
    output logic risePulse
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic syncA, sync2;
    logic [CNT_W-1:0] debCnt;
    always_ff @(posedge fastClk or posedge reset) begin
        if (reset) begin
            syncA <= 1'b0;
            sync2 <= 1'b0;
            debCnt <= '0;
            debounced <= 1'b0;
            risePulse <= 1'b0;
        end else begin
            syncA <= rawBtn;
            sync2 <= syncA;
            risePulse <= 1'b0;
            if (sync2 == debounced)
                debCnt <= '0;
            else if (debCnt == LAST) begin
                debCnt <= '0;
                debounced <= sync2;
                risePulse <= sync2;
            end else
                debCnt <= debCnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/clock_controller.sv
// clock_controller: generates the CPU slow clock in auto or single-step mode with a sticky halt
// fastClk in: the only clock; reset in: async active-high; manualMode in: async, 0 auto / 1 step
// stepBtn in: raw button; haltReq in: fastClk-synchronous HLT request
// slowClk out: registered CPU clock; tickRise out: strobe in the cycle slowClk rises; halted out: HALTED state
module clock_controller
    import clock_pkg::*;
#(
    parameter int DIV_MAX = DIV_MAX_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int CNT_W = 32
) (
    input  logic fastClk,
    input  logic reset,
    input  logic manualMode,
    input  logic stepBtn,
    input  logic haltReq,
    output logic slowClk,
    output logic tickRise,
    output logic halted
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_MAX);
    clkState_t state;
    logic [CNT_W-1:0] phaseCnt;
    logic modeS1, modeS2, haltLatch, stepReq, debounced;
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) debounce (
        .fastClk(fastClk),
        .reset(reset),
        .rawBtn(stepBtn),
        .debounced(debounced),
        .risePulse(stepReq)
    );
    always_ff @(posedge fastClk or posedge reset) begin
        if (reset) begin
            modeS1 <= 1'b0;
            modeS2 <= 1'b0;
            haltLatch <= 1'b0;
            state <= LOW;
            phaseCnt <= '0;
            slowClk <= 1'b0;
            tickRise <= 1'b0;
            halted <= 1'b0;
        end else begin
            modeS1 <= manualMode;
            modeS2 <= modeS1;
            haltLatch <= haltLatch | haltReq;
            tickRise <= 1'b0;
            case (state)
                LOW: begin
                    // The raw request is included so a halt arriving on the terminal count still beats the rise.
                    if (haltLatch | haltReq) begin
                        state <= HALTED;
                        halted <= 1'b1;
                        phaseCnt <= '0;
                    end else if (modeS2 ? stepReq : phaseCnt == LAST) begin
                        state <= HIGH;
                        phaseCnt <= '0;
                        slowClk <= 1'b1;
                        tickRise <= 1'b1;
                    end else
                        phaseCnt <= modeS2 ? '0 : phaseCnt + CNT_W'(1);
                end
                HIGH: begin
                    // The high phase always runs to completion; mode, steps and halt are only honoured in LOW.
                    if (phaseCnt == LAST) begin
                        state <= LOW;
                        phaseCnt <= '0;
                        slowClk <= 1'b0;
                    end else
                        phaseCnt <= phaseCnt + CNT_W'(1);
                end
                default: begin
                    slowClk <= 1'b0;
                    halted <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_clock_controller.sv
// tb_clock_controller: directed scoreboard bench for clock_controller with DIV_MAX=3, DEBOUNCE_CYCLES=4
module tb_clock_controller;
    logic fastClk = 1'b0;
    logic reset = 1'b1;
    logic manualMode = 1'b0;
    logic stepBtn = 1'b0;
    logic haltReq = 1'b0;
    logic slowClk, tickRise, halted;
    int checks = 0;
    int errors = 0;
    typedef struct {
        string tag;
        logic s;
        logic t;
        logic h;
    } exp_t;
    exp_t sb[$];

    always #5 fastClk = ~fastClk;

    clock_controller #(.DIV_MAX(3), .DEBOUNCE_CYCLES(4), .CNT_W(32)) dut (
        .fastClk(fastClk),
        .reset(reset),
        .manualMode(manualMode),
        .stepBtn(stepBtn),
        .haltReq(haltReq),
        .slowClk(slowClk),
        .tickRise(tickRise),
        .halted(halted)
    );

    task automatic push(input string tag, input logic s, input logic t, input logic h);
        exp_t e;
        e.tag = tag;
        e.s = s;
        e.t = t;
        e.h = h;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard empty: size=%0d expected >0", sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks += 3;
            assert (slowClk === e.s) else begin
                errors++;
                $error("FAIL %s slowClk: got %b expected %b at %0t", e.tag, slowClk, e.s, $time);
            end
            assert (tickRise === e.t) else begin
                errors++;
                $error("FAIL %s tickRise: got %b expected %b at %0t", e.tag, tickRise, e.t, $time);
            end
            assert (halted === e.h) else begin
                errors++;
                $error("FAIL %s halted: got %b expected %b at %0t", e.tag, halted, e.h, $time);
            end
        end
    endtask

    // Expectation applies to the outputs seen just after the next rising edge.
    task automatic cyc(input string tag, input logic s, input logic t, input logic h);
        push(tag, s, t, h);
        @(posedge fastClk);
        #1;
        compare();
    endtask

    // Auto mode from reset release: edge n is high when n mod 8 is 4..7, rising at 4.
    task automatic autoRun(input string tag, input int n);
        for (int i = 1; i <= n; i++)
            cyc(tag, (i % 8) >= 4, (i % 8) == 4, 1'b0);
    endtask

    // Checks the asynchronous clear without any clock edge, then releases just after an edge.
    task automatic doReset();
        reset = 1'b1;
        #1;
        push("reset", 1'b0, 1'b0, 1'b0);
        compare();
        @(posedge fastClk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #2;
        doReset();
        autoRun("auto", 40);

        manualMode = 1'b1;
        doReset();
        for (int i = 0; i < 4; i++) cyc("manual_idle", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            stepBtn = ((i / 2) % 2) == 1;
            cyc("bounce", 1'b0, 1'b0, 1'b0);
        end
        stepBtn = 1'b1;
        for (int j = 0; j < 20; j++) cyc("manual_step", j >= 6 && j <= 9, j == 6, 1'b0);

        manualMode = 1'b0;
        stepBtn = 1'b1;
        doReset();
        for (int n = 1; n <= 20; n++) begin
            cyc("mode_switch", n >= 4 && n <= 7, n == 4, 1'b0);
            if (n == 5) manualMode = 1'b1;
        end
        stepBtn = 1'b0;
        for (int i = 0; i < 10; i++) cyc("release", 1'b0, 1'b0, 1'b0);
        stepBtn = 1'b1;
        for (int j = 0; j < 16; j++) cyc("repress", j >= 6 && j <= 9, j == 6, 1'b0);

        manualMode = 1'b0;
        stepBtn = 1'b0;
        doReset();
        autoRun("pre_halt", 4);
        haltReq = 1'b1;
        cyc("halt_high", 1'b1, 1'b0, 1'b0);
        haltReq = 1'b0;
        cyc("halt_high", 1'b1, 1'b0, 1'b0);
        cyc("halt_high", 1'b1, 1'b0, 1'b0);
        cyc("halt_high_end", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) cyc("halted", 1'b0, 1'b0, 1'b1);

        doReset();
        autoRun("after_halt", 16);

        doReset();
        autoRun("pre_halt_low", 3);
        haltReq = 1'b1;
        cyc("halt_low", 1'b0, 1'b0, 1'b1);
        haltReq = 1'b0;
        for (int i = 0; i < 10; i++) cyc("halt_low_hold", 1'b0, 1'b0, 1'b1);

        doReset();
        autoRun("pre_async", 5);
        #2;
        doReset();
        autoRun("after_async", 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
